// File: rtl/btn_pkg.sv
// Shared encodings for the push-button step debouncer: FSM states,
// repeat phases and a small constant helper.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    typedef enum logic {
        DELAY,
        PERIOD
    } rep_phase_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit, with a
// configurable value loaded on synchronous reset.
module sync_2ff #(
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_step_debounce.sv
// Turns a raw bouncing push-button into a debounced level, press/release
// pulses and single-cycle step pulses with auto-repeat while held.
module button_step_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic step_pulse
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] D_LAST      = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic          POL         = (ACTIVE_LOW != 0);

    btn_state_t      state;
    rep_phase_t      rphase;
    logic [DW-1:0]   dcnt;
    logic [RW-1:0]   rcnt;
    logic [RW-1:0]   rep_last;
    logic            btn_pol;
    logic            btn_s;

    assign btn_pol  = btn_in ^ POL;
    assign rep_last = (rphase == DELAY) ? DELAY_LAST : PERIOD_LAST;

    sync_2ff #(
        .RESET_VALUE (1'b0)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_pol),
        .q   (btn_s)
    );

    // The repeat counter only advances in HELD, so a rejected release glitch
    // simply pauses the schedule rather than restarting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rphase        <= DELAY;
            dcnt          <= '0;
            rcnt          <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step_pulse    <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (dcnt == D_LAST) begin
                        state       <= HELD;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        step_pulse  <= 1'b1;
                        rcnt        <= '0;
                        rphase      <= DELAY;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rcnt == rep_last) begin
                            step_pulse <= 1'b1;
                            rcnt       <= '0;
                            rphase     <= PERIOD;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= HELD;
                    end else if (dcnt == D_LAST) begin
                        state         <= IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_step_debounce.sv
// Directed bench for button_step_debounce: a vector table for the basic
// press/repeat/release flow plus hand-written multi-cycle sequences.
module tb_button_step_debounce;

    logic clk;
    logic rst;
    logic btn;
    logic btn_al;

    logic btn_level, press_pulse, release_pulse, step_pulse;
    logic al_level, al_press, al_release, al_step;

    logic [3:0] main_out;
    logic [3:0] al_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       btn;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    assign main_out = {btn_level, press_pulse, release_pulse, step_pulse};
    assign al_out   = {al_level, al_press, al_release, al_step};

    button_step_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .ACTIVE_LOW      (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .step_pulse    (step_pulse)
    );

    button_step_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (0),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .ACTIVE_LOW      (1)
    ) dut_al (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_al),
        .btn_level     (al_level),
        .press_pulse   (al_press),
        .release_pulse (al_release),
        .step_pulse    (al_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input int n, input logic r, input logic b, input logic [3:0] e);
        vec_t v;
        v.rst = r;
        v.btn = b;
        v.exp = e;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Inputs change just after an edge; outputs are read 1 ns after the next one.
    task automatic applyStimulus(input logic r, input logic b, input logic ba);
        rst    = r;
        btn    = b;
        btn_al = ba;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got lvl/prs/rel/stp=%b expected %b", name, act, exp);
        end
    endtask

    initial begin
        int al_steps;
        logic b;
        logic r;
        logic [3:0] e;

        rst    = 1'b1;
        btn    = 1'b0;
        btn_al = 1'b1;

        // Press on edge 1, press step at edge 7, repeats at 17 and 20,
        // release seen from edge 21 and qualified at edge 27.
        addVec(2, 1'b1, 1'b0, 4'b0000);
        addVec(2, 1'b0, 1'b0, 4'b0000);
        addVec(6, 1'b0, 1'b1, 4'b0000);
        addVec(1, 1'b0, 1'b1, 4'b1101);
        addVec(9, 1'b0, 1'b1, 4'b1000);
        addVec(1, 1'b0, 1'b1, 4'b1001);
        addVec(2, 1'b0, 1'b1, 4'b1000);
        addVec(1, 1'b0, 1'b1, 4'b1001);
        addVec(6, 1'b0, 1'b0, 4'b1000);
        addVec(1, 1'b0, 1'b0, 4'b0010);
        addVec(3, 1'b0, 1'b0, 4'b0000);

        $display("[TB] table: %0d vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].btn, 1'b1);
            checkOutput($sformatf("vec%0d", i), main_out, vecs[i].exp);
        end

        $display("[TB] bounce rejection");
        for (int rep = 0; rep < 5; rep++) begin
            for (int c = 0; c < 5; c++) begin
                applyStimulus(1'b0, (c < 3), 1'b1);
                checkOutput($sformatf("bounce%0d_%0d", rep, c), main_out, 4'b0000);
            end
        end
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("bounce_tail%0d", c), main_out, 4'b0000);
        end

        $display("[TB] long hold with auto-repeat");
        for (int t = 1; t <= 50; t++) begin
            b = (t <= 40);
            e = {(t >= 7 && t < 47), (t == 7), (t == 47),
                 (t == 7 || (t >= 17 && t <= 42 && (t - 17) % 3 == 0))};
            applyStimulus(1'b0, b, 1'b1);
            checkOutput($sformatf("hold_e%0d", t), main_out, e);
        end

        $display("[TB] release glitch while held");
        for (int t = 1; t <= 35; t++) begin
            b = (t <= 24) && !(t == 10 || t == 11);
            e = {(t >= 7 && t < 31), (t == 7), (t == 31),
                 (t == 7 || t == 20 || t == 23 || t == 26)};
            applyStimulus(1'b0, b, 1'b1);
            checkOutput($sformatf("glitch_e%0d", t), main_out, e);
        end

        $display("[TB] reset in PRESS_WAIT and HELD");
        for (int t = 1; t <= 32; t++) begin
            r = (t == 5 || t == 15);
            b = (t <= 22);
            e = {((t >= 12 && t < 15) || (t >= 22 && t < 29)), (t == 12 || t == 22),
                 (t == 29), (t == 12 || t == 22)};
            applyStimulus(r, b, 1'b1);
            checkOutput($sformatf("rst_e%0d", t), main_out, e);
        end

        $display("[TB] active-low, no repeat");
        for (int t = 0; t < 8; t++) begin
            applyStimulus((t < 3), 1'b0, 1'b1);
            checkOutput($sformatf("al_idle%0d", t), al_out, 4'b0000);
        end
        al_steps = 0;
        for (int t = 1; t <= 60; t++) begin
            if (t <= 50)
                e = {(t >= 7), (t == 7), 1'b0, (t == 7)};
            else
                e = {(t < 57), 1'b0, (t == 57), 1'b0};
            applyStimulus(1'b0, 1'b0, (t > 50));
            if (al_step === 1'b1) al_steps++;
            checkOutput($sformatf("al_e%0d", t), al_out, e);
        end
        checks++;
        if (al_steps != 1) begin
            failures++;
            $display("[TB] FAIL al_step_count: got %0d steps expected 1", al_steps);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
